// File: rtl/audio_player_pkg.sv
// Shared types and constants for the audio player: fetch FSM states, control
// encodings shared with the keyboard interface, and flash geometry defaults.
package audio_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT_FIRST,
    OUT_SECOND
  } fetch_state_t;

  localparam logic FORWARD  = 1'b0;
  localparam logic BACKWARD = 1'b1;
  localparam logic PLAY     = 1'b1;
  localparam logic STOP     = 1'b0;

  localparam int unsigned DEFAULT_ADDR_W = 23;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned SAMPLE_W       = 16;

  localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_LAST_ADDR = 23'h7FFFF;

endpackage

// File: rtl/audio_sample_fetcher_if.sv
// Avalon-MM read-only port between the sample fetcher (master) and the flash
// controller (slave).
interface audio_sample_fetcher_if
  import audio_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic [WORD_W-1:0] flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );

endinterface

// File: rtl/address_stepper.sv
// Combinational next-address logic: modulo step in either direction with
// explicit wrap compares, plus the restart target for the live direction.
module address_stepper
  import audio_player_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEFAULT_LAST_ADDR)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              direction,
  input  logic              restart,
  output logic [ADDR_W-1:0] next_addr_c,
  output logic [ADDR_W-1:0] restart_target_c
);

  logic [ADDR_W-1:0] stepped;

  // LAST_ADDR need not be all-ones, so the wrap points are compared explicitly
  always_comb begin
    stepped          = addr;
    restart_target_c = (direction == BACKWARD) ? LAST_ADDR : '0;
    if (direction == FORWARD) begin
      stepped = (addr >= LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end else begin
      stepped = ((addr == '0) || (addr > LAST_ADDR)) ? LAST_ADDR : addr - ADDR_W'(1);
    end
    next_addr_c = restart ? restart_target_c : stepped;
  end

endmodule

// File: rtl/audio_sample_fetcher.sv
// Walks flash forward or backward, reads 32-bit words over Avalon-MM and emits
// one 16-bit sample per qualifying sample_tick (two samples per word).
module audio_sample_fetcher
  import audio_player_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEFAULT_LAST_ADDR)
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  play_enable,
  input  logic                  direction,
  input  logic                  restart,
  input  logic                  sample_tick,
  audio_sample_fetcher_if.master flash,
  output logic [SAMPLE_W-1:0]   audio_sample,
  output logic                  sample_valid
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              restart_pending_q, restart_pending_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_dir_q, word_dir_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              read_q, read_d;

  logic [ADDR_W-1:0]   next_addr_c;
  logic [ADDR_W-1:0]   restart_target_c;
  logic [SAMPLE_W-1:0] first_half;
  logic [SAMPLE_W-1:0] second_half;
  logic                tick_ok;
  logic                resume_req;

  address_stepper #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_stepper (
    .addr             (addr_q),
    .direction        (direction),
    .restart          (restart),
    .next_addr_c      (next_addr_c),
    .restart_target_c (restart_target_c)
  );

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      target_q          <= '0;
      restart_pending_q <= 1'b0;
      word_q            <= '0;
      word_dir_q        <= FORWARD;
      sample_q          <= '0;
      valid_q           <= 1'b0;
      read_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      target_q          <= target_d;
      restart_pending_q <= restart_pending_d;
      word_q            <= word_d;
      word_dir_q        <= word_dir_d;
      sample_q          <= sample_d;
      valid_q           <= valid_d;
      read_q            <= read_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    target_d          = target_q;
    restart_pending_d = restart_pending_q;
    word_d            = word_q;
    word_dir_d        = word_dir_q;
    sample_d          = sample_q;
    valid_d           = 1'b0;

    tick_ok     = sample_tick && (play_enable == PLAY);
    resume_req  = (play_enable == PLAY);
    first_half  = (word_dir_q == FORWARD) ? word_q[SAMPLE_W-1:0] : word_q[WORD_W-1:SAMPLE_W];
    second_half = (word_dir_q == FORWARD) ? word_q[WORD_W-1:SAMPLE_W] : word_q[SAMPLE_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (restart) begin
          addr_d  = next_addr_c;
          state_d = resume_req ? REQ : IDLE;
        end else if (resume_req) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (restart) begin
          restart_pending_d = 1'b1;
          target_d          = restart_target_c;
        end
        if (!flash.flash_waitrequest) begin
          state_d = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (restart) begin
          restart_pending_d = 1'b1;
          target_d          = restart_target_c;
        end
        if (flash.flash_readdatavalid) begin
          if (restart || restart_pending_q) begin
            // Stale word from before the restart: drop it and refetch at the target
            addr_d  = restart ? restart_target_c : target_q;
            state_d = resume_req ? REQ : IDLE;
          end else begin
            word_d     = flash.flash_readdata;
            word_dir_d = direction;
            state_d    = OUT_FIRST;
          end
        end
      end

      OUT_FIRST: begin
        if (restart) begin
          addr_d  = next_addr_c;
          state_d = resume_req ? REQ : IDLE;
        end else if (tick_ok) begin
          sample_d = first_half;
          valid_d  = 1'b1;
          state_d  = OUT_SECOND;
        end
      end

      OUT_SECOND: begin
        if (restart) begin
          addr_d  = next_addr_c;
          state_d = resume_req ? REQ : IDLE;
        end else if (tick_ok) begin
          sample_d = second_half;
          valid_d  = 1'b1;
          addr_d   = next_addr_c;
          state_d  = (play_enable == STOP) ? IDLE : REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // A fresh entry into REQ is the issue of the target read
    if ((state_d == REQ) && (state_q != REQ)) begin
      restart_pending_d = 1'b0;
    end

    read_d = (state_d == REQ);
  end

  assign flash.flash_read    = read_q;
  assign flash.flash_address = addr_q;
  assign audio_sample        = sample_q;
  assign sample_valid        = valid_q;

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge clk_in) disable iff (!reset_n)
    (flash.flash_read && flash.flash_waitrequest) |=> $stable(flash.flash_address));

  a_read_tracks_req: assert property (@(posedge clk_in) disable iff (!reset_n)
    flash.flash_read == (state_q == REQ));
`endif

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Scoreboard bench for audio_sample_fetcher: expected samples and read
// addresses are queued by the stimulus and checked by independent monitors.
module tb_audio_sample_fetcher;
  import audio_player_pkg::*;

  localparam int unsigned       ADDR_W = 23;
  localparam logic [ADDR_W-1:0] LAST   = 23'h7FFFF;

  logic        clk_in      = 1'b0;
  logic        reset_n     = 1'b1;
  logic        play_enable = 1'b0;
  logic        direction   = 1'b0;
  logic        restart     = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] audio_sample;
  logic        sample_valid;

  audio_sample_fetcher_if #(.ADDR_W(ADDR_W)) flash ();

  audio_sample_fetcher #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST)) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .play_enable  (play_enable),
    .direction    (direction),
    .restart      (restart),
    .sample_tick  (sample_tick),
    .flash        (flash),
    .audio_sample (audio_sample),
    .sample_valid (sample_valid)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]       exp_sample_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       mem0 = 32'hBBBB_AAAA;

  int                wait_cfg = 0;
  int                lat_cfg  = 2;
  int                lat      = 0;
  int                wait_left = 0;
  bit                in_req   = 1'b0;
  logic [ADDR_W-1:0] lat_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    if (a == '0)   return mem0;
    if (a == 23'd1) return 32'h4444_3333;
    if (a == LAST) return 32'h6666_5555;
    return {16'hF000 + a[15:0], 16'h0F00 + a[15:0]};
  endfunction

  // Flash slave model: programmable waitrequest and read latency
  initial begin
    flash.flash_waitrequest   = 1'b0;
    flash.flash_readdatavalid = 1'b0;
    flash.flash_readdata      = '0;
    forever begin
      @(negedge clk_in);
      flash.flash_readdatavalid = 1'b0;
      if (!reset_n) begin
        in_req = 1'b0;
        lat    = 0;
        flash.flash_waitrequest = 1'b0;
      end else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            flash.flash_readdata      = word_at(lat_addr);
            flash.flash_readdatavalid = 1'b1;
          end
        end
        if (flash.flash_read) begin
          if (!in_req) begin
            in_req    = 1'b1;
            wait_left = wait_cfg;
            if (exp_addr_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL rd_addr: got unexpected read at %0h expected none", flash.flash_address);
            end else begin
              check("rd_addr", 32'(flash.flash_address), 32'(exp_addr_q.pop_front()));
            end
          end
          if (wait_left > 0) begin
            flash.flash_waitrequest = 1'b1;
            wait_left--;
          end else begin
            flash.flash_waitrequest = 1'b0;
            in_req   = 1'b0;
            lat      = lat_cfg;
            lat_addr = flash.flash_address;
          end
        end else begin
          flash.flash_waitrequest = 1'b0;
        end
      end
    end
  end

  // Sample monitor
  initial begin
    forever begin
      @(negedge clk_in);
      if (reset_n && sample_valid) begin
        if (exp_sample_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sample_unexpected: got %0h expected none", audio_sample);
        end else begin
          check("sample", 32'(audio_sample), 32'(exp_sample_q.pop_front()));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_tick();
    @(negedge clk_in);
    sample_tick = 1'b1;
    @(negedge clk_in);
    sample_tick = 1'b0;
  endtask

  task automatic wait_loaded();
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk_in);
      #1;
      if (flash.flash_readdatavalid) seen = 1'b1;
    end
    check("readdatavalid_timeout", 32'(seen), 32'd1);
    @(negedge clk_in);
  endtask

  task automatic wait_accept();
    bit hi = 1'b0;
    bit lo = 1'b0;
    for (int k = 0; k < 100 && !lo; k++) begin
      @(posedge clk_in);
      #1;
      if (flash.flash_read) hi = 1'b1;
      else if (hi) lo = 1'b1;
    end
    check("accept_timeout", 32'(lo), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    #1 reset_n = 1'b0;
    cycles(3);
    check("rst_read",   32'(flash.flash_read),    32'd0);
    check("rst_addr",   32'(flash.flash_address), 32'd0);
    check("rst_sample", 32'(audio_sample),        32'd0);
    check("rst_valid",  32'(sample_valid),        32'd0);
    reset_n = 1'b1;
    cycles(2);

    // Forward playback from 0
    exp_addr_q.push_back(23'd0);
    play_enable = 1'b1;
    wait_loaded();
    exp_sample_q.push_back(16'hAAAA);
    pulse_tick();
    exp_sample_q.push_back(16'hBBBB);
    exp_addr_q.push_back(23'd1);
    pulse_tick();
    wait_loaded();

    // Restart to 0, then play backward across the 0 -> LAST wrap
    mem0 = 32'h2222_1111;
    exp_addr_q.push_back(23'd0);
    @(negedge clk_in);
    restart = 1'b1;
    direction = FORWARD;
    @(negedge clk_in);
    restart = 1'b0;
    direction = BACKWARD;
    wait_loaded();
    exp_sample_q.push_back(16'h2222);
    pulse_tick();
    exp_sample_q.push_back(16'h1111);
    exp_addr_q.push_back(LAST);
    pulse_tick();
    wait_loaded();

    // Direction flips mid-word: half order kept, step goes forward LAST -> 0
    exp_sample_q.push_back(16'h6666);
    pulse_tick();
    direction = FORWARD;
    exp_sample_q.push_back(16'h5555);
    exp_addr_q.push_back(23'd0);
    pulse_tick();
    wait_loaded();

    // Pause in OUT_SECOND: ticks ignored, sample held
    exp_sample_q.push_back(16'h1111);
    pulse_tick();
    play_enable = 1'b0;
    repeat (4) begin
      pulse_tick();
      cycles(3);
    end
    check("pause_hold", 32'(audio_sample), 32'h1111);
    check("pause_no_read", 32'(flash.flash_read), 32'd0);
    play_enable = 1'b1;
    cycles(2);
    exp_sample_q.push_back(16'h2222);
    exp_addr_q.push_back(23'd1);
    pulse_tick();
    wait_loaded();

    // Restart together with a tick in OUT_FIRST: tick dropped, read at 0
    exp_addr_q.push_back(23'd0);
    @(negedge clk_in);
    restart = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    sample_tick = 1'b0;
    wait_loaded();

    // Walk forward to address 5; its read stalls for 3 cycles
    for (int i = 0; i < 5; i++) begin
      w = word_at(ADDR_W'(i));
      exp_sample_q.push_back(w[15:0]);
      pulse_tick();
      exp_sample_q.push_back(w[31:16]);
      exp_addr_q.push_back(ADDR_W'(i + 1));
      if (i == 4) begin
        wait_cfg = 3;
        lat_cfg  = 4;
      end
      pulse_tick();
      if (i < 4) wait_loaded();
    end

    // Restart while WAIT_DATA on address 5: word discarded, refetch at 0
    wait_accept();
    exp_addr_q.push_back(23'd0);
    @(negedge clk_in);
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    wait_cfg = 0;
    lat_cfg  = 2;
    wait_loaded();
    wait_loaded();
    check("pending_clear", 32'(dut.restart_pending_q), 32'd0);
    exp_sample_q.push_back(16'h1111);
    pulse_tick();

    // Asynchronous reset while stalled in REQ
    wait_cfg = 50;
    exp_sample_q.push_back(16'h2222);
    exp_addr_q.push_back(23'd1);
    pulse_tick();
    cycles(4);
    check("req_read_high", 32'(flash.flash_read), 32'd1);
    @(posedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    check("arst_read",   32'(flash.flash_read),    32'd0);
    check("arst_addr",   32'(flash.flash_address), 32'd0);
    check("arst_sample", 32'(audio_sample),        32'd0);
    check("arst_valid",  32'(sample_valid),        32'd0);
    check("arst_state",  32'(dut.state_q),         32'(IDLE));
    play_enable = 1'b0;
    cycles(2);
    reset_n  = 1'b1;
    wait_cfg = 0;
    cycles(5);
    check("idle_read",  32'(flash.flash_read), 32'd0);
    check("idle_state", 32'(dut.state_q),      32'(IDLE));

    cycles(5);
    check("addr_q_drained",   32'(exp_addr_q.size()),   32'd0);
    check("sample_q_drained", 32'(exp_sample_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
